// File: rtl/cpu_pipe_pkg.sv
// Shared constants for the five-stage MIPS pipeline: CP0 exception codes,
// handler entry address and the NOP encoding used for bubbles and flushes.
package cpu_pipe_pkg;

  localparam int EXC_W_DEFAULT = 5;

  localparam logic [EXC_W_DEFAULT-1:0] EXC_NONE    = 5'd0;
  localparam logic [EXC_W_DEFAULT-1:0] EXC_INT     = 5'd0;
  localparam logic [EXC_W_DEFAULT-1:0] EXC_ADEL    = 5'd4;
  localparam logic [EXC_W_DEFAULT-1:0] EXC_ADES    = 5'd5;
  localparam logic [EXC_W_DEFAULT-1:0] EXC_SYSCALL = 5'd8;
  localparam logic [EXC_W_DEFAULT-1:0] EXC_RI      = 5'd10;
  localparam logic [EXC_W_DEFAULT-1:0] EXC_OV      = 5'd12;

  localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;
  localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter: sticks at all-ones, cleared only by reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with stall, bubble (keeping pc/BD for
// EPC), flush to the exception handler, exception merge and perf counters.
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int          PAYLOAD_W  = 107,
  parameter int          EXC_W      = 5,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT,
  parameter int          CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 stall,
  input  logic                 bubble,
  input  logic                 in_valid,
  input  logic [31:0]          in_instr,
  input  logic [31:0]          in_pc,
  input  logic                 in_isbd,
  input  logic [EXC_W-1:0]     in_exc,
  input  logic [EXC_W-1:0]     local_exc,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  output logic [31:0]          out_instr,
  output logic [31:0]          out_pc,
  output logic                 out_isbd,
  output logic [EXC_W-1:0]     out_exc,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam logic [EXC_W-1:0] W_EXC_NONE = EXC_W'(EXC_NONE);

  logic                 r_valid;
  logic [31:0]          r_instr;
  logic [31:0]          r_pc;
  logic                 r_isbd;
  logic [EXC_W-1:0]     r_exc;
  logic [PAYLOAD_W-1:0] r_payload;

  logic             w_bubble_ld;
  logic [EXC_W-1:0] w_merged_exc;

  assign w_bubble_ld = !flush && !stall && bubble;

  // Earliest stage's exception wins; a non-instruction never carries one.
  always_comb begin
    w_merged_exc = W_EXC_NONE;
    if (in_valid) begin
      w_merged_exc = (in_exc != W_EXC_NONE) ? in_exc : local_exc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_instr   <= '0;
      r_pc      <= '0;
      r_isbd    <= 1'b0;
      r_exc     <= '0;
      r_payload <= '0;
    end else if (flush) begin
      r_valid   <= 1'b0;
      r_instr   <= NOP_INSTR;
      r_pc      <= HANDLER_PC;
      r_isbd    <= 1'b0;
      r_exc     <= W_EXC_NONE;
      r_payload <= '0;
    end else if (!stall) begin
      if (bubble) begin
        r_valid   <= 1'b0;
        r_instr   <= NOP_INSTR;
        r_pc      <= in_pc;
        r_isbd    <= in_isbd;
        r_exc     <= W_EXC_NONE;
        r_payload <= '0;
      end else begin
        r_valid   <= in_valid;
        r_instr   <= in_instr;
        r_pc      <= in_pc;
        r_isbd    <= in_isbd;
        r_exc     <= w_merged_exc;
        r_payload <= in_payload;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_inc  (w_bubble_ld),
    .o_count(bubble_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_inc  (flush),
    .o_count(flush_cnt)
  );

  assign out_valid   = r_valid;
  assign out_instr   = r_instr;
  assign out_pc      = r_pc;
  assign out_isbd    = r_isbd;
  assign out_exc     = r_exc;
  assign out_payload = r_payload;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a reference model pushes expected output vectors
// each cycle; every scenario task pops and compares after the clock edge.
module tb_pipe_stage_reg;
  import cpu_pipe_pkg::*;

  localparam int          PW   = 107;
  localparam int          EW   = 5;
  localparam int          CW   = 2;
  localparam logic [31:0] HPC  = 32'h0000_4180;
  localparam int          SB_W = 1 + 32 + 32 + 1 + EW + PW + 2 * CW;

  logic          clk = 1'b0;
  logic          reset, flush, stall, bubble;
  logic          in_valid, in_isbd;
  logic [31:0]   in_instr, in_pc;
  logic [EW-1:0] in_exc, local_exc;
  logic [PW-1:0] in_payload;
  logic          out_valid, out_isbd;
  logic [31:0]   out_instr, out_pc;
  logic [EW-1:0] out_exc;
  logic [PW-1:0] out_payload;
  logic [CW-1:0] bubble_cnt, flush_cnt;

  pipe_stage_reg #(
    .PAYLOAD_W(PW), .EXC_W(EW), .HANDLER_PC(HPC), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall), .bubble(bubble),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_isbd(in_isbd),
    .in_exc(in_exc), .local_exc(local_exc), .in_payload(in_payload),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_isbd(out_isbd), .out_exc(out_exc), .out_payload(out_payload),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard state
  logic [SB_W-1:0] exp_q[$];
  logic [SB_W-1:0] exp;
  int checks = 0;
  int passed = 0;

  // Reference model state
  logic          m_valid = 1'b0, m_isbd = 1'b0;
  logic [31:0]   m_instr = '0, m_pc = '0;
  logic [EW-1:0] m_exc = '0;
  logic [PW-1:0] m_payload = '0;
  logic [CW-1:0] m_bc = '0, m_fc = '0;

  function automatic logic [SB_W-1:0] obs_vec();
    return {out_valid, out_instr, out_pc, out_isbd, out_exc, out_payload, bubble_cnt, flush_cnt};
  endfunction

  function automatic logic [PW-1:0] rand_payload();
    return PW'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic idle_inputs();
    reset = 0; flush = 0; stall = 0; bubble = 0;
    in_valid = 0; in_instr = '0; in_pc = '0; in_isbd = 0;
    in_exc = '0; local_exc = '0; in_payload = '0;
  endtask

  // Advance the model from the current inputs, queue the expectation, clock.
  task automatic tick();
    if (reset) begin
      m_valid = 0; m_instr = '0; m_pc = '0; m_isbd = 0; m_exc = '0; m_payload = '0;
      m_bc = '0; m_fc = '0;
    end else if (flush) begin
      m_valid = 0; m_instr = '0; m_pc = HPC; m_isbd = 0; m_exc = '0; m_payload = '0;
      if (m_fc != {CW{1'b1}}) m_fc = m_fc + 1'b1;
    end else if (stall) begin
      m_valid = m_valid;
    end else if (bubble) begin
      m_valid = 0; m_instr = '0; m_exc = '0; m_payload = '0;
      m_pc = in_pc; m_isbd = in_isbd;
      if (m_bc != {CW{1'b1}}) m_bc = m_bc + 1'b1;
    end else begin
      m_valid = in_valid; m_instr = in_instr; m_pc = in_pc; m_isbd = in_isbd;
      m_payload = in_payload;
      m_exc = !in_valid ? '0 : ((in_exc != '0) ? in_exc : local_exc);
    end
    exp_q.push_back({m_valid, m_instr, m_pc, m_isbd, m_exc, m_payload, m_bc, m_fc});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick();
    exp = exp_q.pop_front();
    checks++; if (obs_vec() !== exp) $display("FAIL reset_sb: got %h expected %h", obs_vec(), exp); else passed++;
    checks++; if (obs_vec() !== '0) $display("FAIL reset_zero: got %h expected 0", obs_vec()); else passed++;
    reset = 0;
  endtask

  task automatic test_load();
    idle_inputs();
    in_valid = 1; in_instr = 32'h8C41_0004; in_pc = 32'h0000_3004; in_payload = PW'(5);
    tick();
    exp = exp_q.pop_front();
    checks++; if (obs_vec() !== exp) $display("FAIL load_sb: got %h expected %h", obs_vec(), exp); else passed++;
    checks++; if (out_instr !== 32'h8C41_0004 || out_pc !== 32'h3004 || out_valid !== 1'b1 || out_exc !== '0 || out_payload !== PW'(5))
      $display("FAIL load_fields: got instr=%h pc=%h v=%b exc=%0d expected 8c410004/3004/1/0", out_instr, out_pc, out_valid, out_exc);
    else passed++;
  endtask

  task automatic test_exc_merge();
    logic [EW-1:0] t_in[3]    = '{EXC_NONE, EXC_ADEL, EXC_NONE};
    logic [EW-1:0] t_loc[3]   = '{EXC_OV, EXC_OV, EXC_RI};
    logic          t_val[3]   = '{1'b1, 1'b1, 1'b0};
    logic [EW-1:0] t_exp[3]   = '{5'd12, 5'd4, 5'd0};
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      in_valid = t_val[i]; in_exc = t_in[i]; local_exc = t_loc[i];
      in_instr = $urandom; in_pc = 32'h3008 + 32'(i * 4); in_payload = rand_payload();
      tick();
      exp = exp_q.pop_front();
      checks++; if (obs_vec() !== exp) $display("FAIL exc_merge_sb[%0d]: got %h expected %h", i, obs_vec(), exp); else passed++;
      checks++; if (out_exc !== t_exp[i]) $display("FAIL exc_merge[%0d]: got %0d expected %0d", i, out_exc, t_exp[i]); else passed++;
    end
  endtask

  task automatic test_bubble();
    idle_inputs();
    bubble = 1; in_valid = 1; in_instr = 32'h2002_0001; in_pc = 32'h0000_3010; in_isbd = 1;
    in_exc = EXC_SYSCALL; in_payload = rand_payload();
    tick();
    exp = exp_q.pop_front();
    checks++; if (obs_vec() !== exp) $display("FAIL bubble_sb: got %h expected %h", obs_vec(), exp); else passed++;
    checks++; if (out_instr !== 32'h0 || out_valid !== 1'b0 || out_pc !== 32'h3010 || out_isbd !== 1'b1 || bubble_cnt !== CW'(1))
      $display("FAIL bubble_fields: got instr=%h v=%b pc=%h bd=%b cnt=%0d expected 0/0/3010/1/1", out_instr, out_valid, out_pc, out_isbd, bubble_cnt);
    else passed++;
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      stall = 1; bubble = 1; in_valid = 1; in_instr = $urandom; in_pc = $urandom;
      in_isbd = 0; local_exc = EXC_ADES; in_payload = rand_payload();
      tick();
      exp = exp_q.pop_front();
      checks++; if (obs_vec() !== exp) $display("FAIL stall_sb[%0d]: got %h expected %h", i, obs_vec(), exp); else passed++;
      checks++; if (out_pc !== 32'h3010 || bubble_cnt !== CW'(1))
        $display("FAIL stall_hold[%0d]: got pc=%h cnt=%0d expected 3010/1", i, out_pc, bubble_cnt);
      else passed++;
    end
  endtask

  task automatic test_flush();
    idle_inputs();
    flush = 1; stall = 1; bubble = 1; in_valid = 1; in_instr = $urandom; in_pc = 32'h3020;
    in_payload = rand_payload();
    tick();
    exp = exp_q.pop_front();
    checks++; if (obs_vec() !== exp) $display("FAIL flush_sb: got %h expected %h", obs_vec(), exp); else passed++;
    checks++; if (out_pc !== 32'h4180 || out_instr !== 32'h0 || out_valid !== 1'b0 || flush_cnt !== CW'(1) || bubble_cnt !== CW'(1))
      $display("FAIL flush_fields: got pc=%h instr=%h v=%b fcnt=%0d bcnt=%0d expected 4180/0/0/1/1", out_pc, out_instr, out_valid, flush_cnt, bubble_cnt);
    else passed++;
  endtask

  task automatic test_saturate();
    logic [CW-1:0] exp_bc[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    idle_inputs();
    reset = 1;
    tick();
    exp = exp_q.pop_front();
    checks++; if (obs_vec() !== exp) $display("FAIL sat_reset_sb: got %h expected %h", obs_vec(), exp); else passed++;
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      bubble = 1; in_pc = 32'h5000 + 32'(i * 4);
      tick();
      exp = exp_q.pop_front();
      checks++; if (obs_vec() !== exp) $display("FAIL sat_sb[%0d]: got %h expected %h", i, obs_vec(), exp); else passed++;
      checks++; if (bubble_cnt !== exp_bc[i]) $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, bubble_cnt, exp_bc[i]); else passed++;
    end
    idle_inputs();
    reset = 1; bubble = 1; in_pc = 32'h5100;
    tick();
    exp = exp_q.pop_front();
    checks++; if (obs_vec() !== '0) $display("FAIL sat_mid_reset: got %h expected 0", obs_vec()); else passed++;
  endtask

  task automatic test_reset_priority();
    idle_inputs();
    in_valid = 1; in_instr = 32'h0123_4567; in_pc = 32'h6000; in_exc = EXC_RI; in_payload = rand_payload();
    tick();
    exp = exp_q.pop_front();
    checks++; if (obs_vec() !== exp) $display("FAIL rstprio_load_sb: got %h expected %h", obs_vec(), exp); else passed++;
    idle_inputs();
    flush = 1;
    tick();
    exp = exp_q.pop_front();
    checks++; if (obs_vec() !== exp) $display("FAIL rstprio_flush_sb: got %h expected %h", obs_vec(), exp); else passed++;
    idle_inputs();
    reset = 1; flush = 1; stall = 1;
    tick();
    exp = exp_q.pop_front();
    checks++; if (obs_vec() !== '0) $display("FAIL rstprio_zero: got %h expected 0", obs_vec()); else passed++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 80; i++) begin
      idle_inputs();
      flush  = ($urandom_range(0, 9) == 0);
      stall  = ($urandom_range(0, 4) == 0);
      bubble = ($urandom_range(0, 3) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_instr = $urandom; in_pc = $urandom; in_isbd = 1'($urandom_range(0, 1));
      in_exc = ($urandom_range(0, 2) == 0) ? EW'($urandom_range(1, 31)) : '0;
      local_exc = ($urandom_range(0, 1) == 0) ? EW'($urandom_range(1, 31)) : '0;
      in_payload = rand_payload();
      tick();
      exp = exp_q.pop_front();
      checks++; if (obs_vec() !== exp) $display("FAIL b2b_sb[%0d]: got %h expected %h", i, obs_vec(), exp); else passed++;
    end
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_load();
    test_exc_merge();
    test_bubble();
    test_stall();
    test_flush();
    test_saturate();
    test_reset_priority();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
